// File: rtl/imem_pkg.sv
// Shared instruction-memory constants, loader FSM states and the load-length clamp.
package imem_pkg;
  localparam int IMEM_ADDR_W = 12;
  localparam int IMEM_XLEN   = 32;
  localparam logic [IMEM_XLEN-IMEM_ADDR_W-1:0] IMEM_BASE_HI = 20'hBFC00;
  localparam logic [IMEM_ADDR_W:0] IMEM_FULL = {1'b1, {IMEM_ADDR_W{1'b0}}};

  typedef enum logic [1:0] {RUN, LOAD, FLUSH} ld_state_e;

  // Zero or anything past the end of memory means "fill the whole memory".
  function automatic logic [IMEM_ADDR_W:0] clamp_len(input logic [IMEM_ADDR_W:0] len);
    if (len == '0 || len > IMEM_FULL) return IMEM_FULL;
    return len;
  endfunction
endpackage

// File: rtl/imem_load_fetch_ctrl_if.sv
// Fetch, loader and memory-port bundle; slave side is the controller.
interface imem_load_fetch_ctrl_if #(
  parameter int ADDR_W = imem_pkg::IMEM_ADDR_W,
  parameter int XLEN   = imem_pkg::IMEM_XLEN
);
  logic              fetch_req;
  logic [XLEN-1:0]   fetch_pc;
  logic              fetch_valid;
  logic [XLEN-1:0]   fetch_instr;
  logic              fetch_fault;
  logic              cpu_hold;
  logic              ld_start;
  logic [ADDR_W:0]   ld_len;
  logic              ld_valid;
  logic [7:0]        ld_data;
  logic              ld_ready;
  logic              ld_done;
  logic [ADDR_W-1:0] mem_raddr;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;

  modport slave (
    input  fetch_req, fetch_pc, ld_start, ld_len, ld_valid, ld_data, mem_rdata,
    output fetch_valid, fetch_instr, fetch_fault, cpu_hold, ld_ready, ld_done,
           mem_raddr, mem_we, mem_waddr, mem_wdata
  );
  modport master (
    output fetch_req, fetch_pc, ld_start, ld_len, ld_valid, ld_data, mem_rdata,
    input  fetch_valid, fetch_instr, fetch_fault, cpu_hold, ld_ready, ld_done,
           mem_raddr, mem_we, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/imem_load_fetch_ctrl_fetch_check.sv
// Fetch PC legality: must sit inside the boot window and be word aligned.
module imem_fetch_check #(
  parameter int ADDR_W = 12,
  parameter int XLEN   = 32,
  parameter logic [XLEN-ADDR_W-1:0] BASE_HI = '0
) (
  input  logic [XLEN-ADDR_W-1:0] pc_hi,
  input  logic [1:0]             pc_lo,
  output logic                   fault
);
  assign fault = (pc_hi != BASE_HI) || (pc_lo != 2'b00);
endmodule

// File: rtl/imem_load_fetch_ctrl.sv
// Arbitrates the instruction memory between CPU fetch (registered reads) and the
// byte-stream loader, which owns the memory and stalls the CPU while it runs.
module imem_load_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int XLEN   = IMEM_XLEN,
  parameter logic [XLEN-ADDR_W-1:0] BASE_HI = IMEM_BASE_HI
) (
  input  logic                  clk,
  input  logic                  rst,
  imem_load_fetch_ctrl_if.slave bus
);
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  ld_state_e       state;
  logic [ADDR_W:0] cnt, len;
  logic            pc_fault;
  logic            fetch_valid_q, fetch_fault_q, cpu_hold_q, ld_ready_q, ld_done_q;
  logic [XLEN-1:0] fetch_instr_q;

  imem_fetch_check #(.ADDR_W(ADDR_W), .XLEN(XLEN), .BASE_HI(BASE_HI)) u_fetch_check (
    .pc_hi (bus.fetch_pc[XLEN-1:ADDR_W]),
    .pc_lo (bus.fetch_pc[1:0]),
    .fault (pc_fault)
  );

  assign bus.mem_raddr   = {bus.fetch_pc[ADDR_W-1:2], 2'b00};
  // ld_ready is high exactly in LOAD, so writes can never collide with a fetch read.
  assign bus.mem_we      = ld_ready_q & bus.ld_valid;
  assign bus.mem_waddr   = cnt[ADDR_W-1:0];
  assign bus.mem_wdata   = bus.ld_data;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_instr = fetch_instr_q;
  assign bus.fetch_fault = fetch_fault_q;
  assign bus.cpu_hold    = cpu_hold_q;
  assign bus.ld_ready    = ld_ready_q;
  assign bus.ld_done     = ld_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      cnt           <= '0;
      len           <= '0;
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= '0;
      fetch_fault_q <= 1'b0;
      cpu_hold_q    <= 1'b0;
      ld_ready_q    <= 1'b0;
      ld_done_q     <= 1'b0;
    end else begin
      fetch_valid_q <= 1'b0;
      ld_done_q     <= 1'b0;
      unique case (state)
        RUN: begin
          if (bus.ld_start) begin
            // Loader wins; a fetch in the same cycle is dropped.
            state      <= LOAD;
            cnt        <= '0;
            len        <= clamp_len(bus.ld_len);
            cpu_hold_q <= 1'b1;
            ld_ready_q <= 1'b1;
          end else if (bus.fetch_req) begin
            fetch_valid_q <= 1'b1;
            fetch_fault_q <= pc_fault;
            fetch_instr_q <= pc_fault ? '0 : bus.mem_rdata;
          end
        end
        LOAD: begin
          if (bus.ld_valid) begin
            cnt <= cnt + ONE;
            if (cnt == len - ONE) begin
              state      <= FLUSH;
              ld_ready_q <= 1'b0;
              ld_done_q  <= 1'b1;
            end
          end
        end
        FLUSH: begin
          state      <= RUN;
          cpu_hold_q <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_load_fetch_ctrl.sv
// Directed bench: fetch and write scoreboards fed at stimulus time, drained by negedge monitors.
module tb_imem_load_fetch_ctrl;
  import imem_pkg::*;

  typedef struct {logic [31:0] instr; logic fault;} fexp_t;
  typedef struct {logic [11:0] addr; logic [7:0] data;} wexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  always #5 clk = ~clk;

  imem_load_fetch_ctrl_if bus();
  imem_load_fetch_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] mem     [4096];
  logic [7:0] exp_mem [4096];
  fexp_t fq[$];
  wexp_t wq[$];
  fexp_t fe;
  wexp_t we;
  int tests = 0, fails = 0, done_cnt = 0, wr_cnt = 0;
  logic [11:0] last_waddr = '0;

  always_comb begin
    bus.mem_rdata = {mem[int'(bus.mem_raddr) + 3], mem[int'(bus.mem_raddr) + 2],
                     mem[int'(bus.mem_raddr) + 1], mem[int'(bus.mem_raddr)]};
  end

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) mem[i] <= exp_mem[i];
    end else if (bus.mem_we) begin
      mem[bus.mem_waddr] <= bus.mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.ld_done === 1'b1) done_cnt++;
    if (bus.fetch_valid === 1'b1) begin
      if (fq.size() == 0) chk("fetch_unexpected", 32'(bus.fetch_valid), 32'd0);
      else begin
        fe = fq.pop_front();
        chk("fetch_instr", bus.fetch_instr, fe.instr);
        chk("fetch_fault", 32'(bus.fetch_fault), 32'(fe.fault));
      end
    end
    if (bus.mem_we === 1'b1) begin
      wr_cnt++;
      last_waddr = bus.mem_waddr;
      if (wq.size() == 0) chk("write_unexpected", 32'(bus.mem_we), 32'd0);
      else begin
        we = wq.pop_front();
        chk("mem_waddr", 32'(bus.mem_waddr), 32'(we.addr));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(we.data));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    fexp_t e;
    int a;
    a = int'(pc[11:0]);
    if (pc[31:12] == 20'hBFC00 && pc[1:0] == 2'b00)
      e = '{{exp_mem[a+3], exp_mem[a+2], exp_mem[a+1], exp_mem[a]}, 1'b0};
    else
      e = '{32'h0, 1'b1};
    fq.push_back(e);
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = pc;
    cyc();
    bus.fetch_req = 1'b0;
    chk("fetch_valid", 32'(bus.fetch_valid), 32'd1);
  endtask

  task automatic start_load(input logic [12:0] len);
    bus.ld_start = 1'b1;
    bus.ld_len   = len;
    cyc();
    bus.ld_start = 1'b0;
    chk("load_hold", 32'(bus.cpu_hold), 32'd1);
    chk("load_ready", 32'(bus.ld_ready), 32'd1);
  endtask

  task automatic send_byte(input logic [11:0] a, input logic [7:0] d);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    wq.push_back('{a, d});
    exp_mem[a] = d;
    cyc();
    bus.ld_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: timeout, observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, w0;
    bus.fetch_req = 1'b0; bus.fetch_pc = '0; bus.ld_start = 1'b0; bus.ld_len = '0;
    bus.ld_valid = 1'b1; bus.ld_data = 8'h5A;
    for (int i = 0; i < 4096; i++) exp_mem[i] = 8'($urandom);
    {exp_mem[7], exp_mem[6], exp_mem[5], exp_mem[4]} = 32'h00500093;
    cyc(); cyc();
    preload = 1'b0;
    chk("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    chk("rst_fetch_instr", bus.fetch_instr, 32'd0);
    chk("rst_fetch_fault", 32'(bus.fetch_fault), 32'd0);
    chk("rst_cpu_hold", 32'(bus.cpu_hold), 32'd0);
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("rst_ld_done", 32'(bus.ld_done), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    rst = 1'b0;
    cyc();
    chk("run_we_blocked", 32'(bus.mem_we), 32'd0);
    bus.ld_valid = 1'b0;

    // Fetch: good word, out-of-window, misaligned, wrong segment.
    fetch(32'hBFC0_0004);
    chk("raddr_aligned", 32'(bus.mem_raddr), 32'h004);
    fetch(32'hBFC0_1000);
    fetch(32'hBFC0_0002);
    fetch(32'h0000_0004);
    fetch(32'hBFC0_0004);
    cyc();
    chk("idle_valid", 32'(bus.fetch_valid), 32'd0);
    chk("idle_instr_hold", bus.fetch_instr, 32'h00500093);

    // Eight-byte load with ld_valid gaps; stray bytes offered in FLUSH and RUN.
    d0 = done_cnt;
    start_load(13'd8);
    for (int i = 0; i < 8; i++) begin
      if (i % 3 == 1) begin
        cyc();
        chk("gap_hold", 32'(bus.cpu_hold), 32'd1);
      end
      send_byte(12'(i), 8'(8'h11 * (i + 1)));
      if (i < 7) chk("load_hold_mid", 32'(bus.cpu_hold), 32'd1);
    end
    bus.ld_valid = 1'b1; bus.ld_data = 8'hEE;
    #1;
    chk("flush_done", 32'(bus.ld_done), 32'd1);
    chk("flush_hold", 32'(bus.cpu_hold), 32'd1);
    chk("flush_ready", 32'(bus.ld_ready), 32'd0);
    chk("flush_we", 32'(bus.mem_we), 32'd0);
    cyc();
    chk("post_hold", 32'(bus.cpu_hold), 32'd0);
    chk("post_done", 32'(bus.ld_done), 32'd0);
    chk("post_we", 32'(bus.mem_we), 32'd0);
    cyc();
    bus.ld_valid = 1'b0;
    chk("done_once_8", 32'(done_cnt - d0), 32'd1);
    for (int i = 0; i < 8; i++) chk("img8", 32'(mem[i]), 32'(exp_mem[i]));
    fetch(32'hBFC0_0000);
    fetch(32'hBFC0_0004);

    // Full-memory load via ld_len=0, with a stray ld_start mid-load.
    d0 = done_cnt; w0 = wr_cnt;
    start_load(13'd0);
    for (int i = 0; i < 4096; i++) begin
      if (i == 100) begin bus.ld_start = 1'b1; bus.ld_len = 13'd2; end
      send_byte(12'(i), 8'(i) ^ 8'hA5);
      bus.ld_start = 1'b0;
    end
    chk("full_done", 32'(bus.ld_done), 32'd1);
    chk("full_last_waddr", 32'(last_waddr), 32'hFFF);
    chk("full_writes", 32'(wr_cnt - w0), 32'd4096);
    cyc();
    chk("done_once_full", 32'(done_cnt - d0), 32'd1);
    fetch(32'hBFC0_0FFC);
    fetch(32'hBFC0_0000);

    // Load start collides with a fetch: the fetch is dropped.
    bus.ld_start = 1'b1; bus.ld_len = 13'd2;
    bus.fetch_req = 1'b1; bus.fetch_pc = 32'hBFC0_0004;
    cyc();
    bus.ld_start = 1'b0; bus.fetch_req = 1'b0;
    chk("collide_valid", 32'(bus.fetch_valid), 32'd0);
    chk("collide_hold", 32'(bus.cpu_hold), 32'd1);
    send_byte(12'h000, 8'hA1);
    send_byte(12'h001, 8'hA2);
    cyc();
    chk("collide_run", 32'(bus.cpu_hold), 32'd0);

    // Reset after three of eight bytes: partial image kept, no ld_done.
    d0 = done_cnt;
    start_load(13'd8);
    send_byte(12'h000, 8'hC1);
    send_byte(12'h001, 8'hC2);
    send_byte(12'h002, 8'hC3);
    rst = 1'b1;
    #1;
    chk("rst_mid_hold", 32'(bus.cpu_hold), 32'd0);
    chk("rst_mid_ready", 32'(bus.ld_ready), 32'd0);
    chk("rst_mid_done", 32'(bus.ld_done), 32'd0);
    cyc();
    rst = 1'b0;
    cyc(); cyc(); cyc();
    chk("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rst_mid_run", 32'(bus.cpu_hold), 32'd0);
    fetch(32'hBFC0_0000);
    cyc(); cyc();
    chk("fetch_sb_empty", 32'(fq.size()), 32'd0);
    chk("write_sb_empty", 32'(wq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
